// File: rtl/rr_encoder.sv
// rr_encoder: round-robin request encoder.
// Arbitrates 2**WIDTH request lines with a rotating priority pointer. The
// winner's index is offered as a binary code over a valid/ready handshake.
// After each accepted grant, the pointer moves to the line just past the winner.
// All outputs are registered. Reset is asynchronous and active-high.
// Optional feature: define RR_ENCODER_LATCH_EN to hold single-cycle request
// pulses in a pending register until they are granted.

module rr_encoder #(
    parameter int WIDTH = 4
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [(2**WIDTH)-1:0]   req_i,
    input  logic                    code_ready_i,
    output logic                    code_valid_o,
    output logic [WIDTH-1:0]        code_o
);

    localparam int N = 2**WIDTH;

    typedef enum logic {
        IDLE  = 1'b0,
        OFFER = 1'b1
    } state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] ptr_q, ptr_d;
    logic [WIDTH-1:0] code_q, code_d;
    logic             valid_q, valid_d;
    logic [N-1:0]     elig;
    logic [WIDTH-1:0] win_idx;
    logic [WIDTH-1:0] cand;
    logic             handshake;

    assign handshake = valid_q & code_ready_i;

`ifdef RR_ENCODER_LATCH_EN
    logic [N-1:0] pending_q, pending_d;

    // Remember every request seen. The granted line is dropped on handshake
    // unless it is requested again in that same cycle.
    always_comb begin
        // NOTE: every combinational output gets a default first, so no path leaves it unassigned and no latch is inferred.
        pending_d = pending_q | req_i;
        if (handshake) begin
            pending_d[code_q] = req_i[code_q];
        end
    end

    // Pending register, cleared by reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pending_q <= '0;
        end else begin
            pending_q <= pending_d;
        end
    end

    assign elig = req_i | pending_q;
`else
    assign elig = req_i;
`endif

    // Rotating-priority search. Scan from the highest offset down so that the
    // last hit is the lowest offset at or above ptr, wrapping modulo N.
    always_comb begin
        win_idx = ptr_q;
        cand    = ptr_q;
        for (int k = N - 1; k >= 0; k--) begin
            cand = ptr_q + WIDTH'(k);
            if (elig[cand]) begin
                win_idx = cand;
            end
        end
    end

    // State register, plus the pointer and the registered outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            // NOTE: non-blocking assignments here, so that every register samples pre-edge values.
            state_q <= IDLE;
            ptr_q   <= '0;
            code_q  <= '0;
            valid_q <= 1'b0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            code_q  <= code_d;
            valid_q <= valid_d;
        end
    end

    // Next-state logic. An offer is left only when the handshake completes.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (|elig)        state_d = OFFER;
            OFFER:   if (code_ready_i) state_d = IDLE;
            default:                   state_d = IDLE;
        endcase
    end

    // Output and pointer next values. A grant is latched in IDLE and stays
    // unchanged until it is accepted. Acceptance moves the pointer past the winner.
    always_comb begin
        code_d  = code_q;
        ptr_d   = ptr_q;
        valid_d = 1'b0;
        case (state_q)
            IDLE: begin
                if (|elig) begin
                    code_d  = win_idx;
                    valid_d = 1'b1;
                end
            end
            OFFER: begin
                valid_d = 1'b1;
                if (code_ready_i) begin
                    valid_d = 1'b0;
                    ptr_d   = code_q + 1'b1;
                end
            end
            default: begin
                valid_d = 1'b0;
            end
        endcase
    end

    assign code_valid_o = valid_q;
    assign code_o       = code_q;

endmodule

// File: tb/tb_rr_encoder.sv
// Testbench for rr_encoder with WIDTH=2 (four request lines).
// A behavioural model runs alongside the DUT. A single compare process checks
// the DUT against the model on every falling edge. Directed vectors add
// hand-computed literal checks that pin down the model. Honours
// RR_ENCODER_LATCH_EN in the same way as the design.

module tb_rr_encoder;

    localparam int W = 2;
    localparam int N = 4;

    logic         clk;
    logic         rst;
    logic [N-1:0] req;
    logic         code_ready;
    logic         code_valid;
    logic [W-1:0] code;

    int checks   = 0;
    int failures = 0;

    rr_encoder #(.WIDTH(W)) dut (
        .clk          (clk),
        .rst          (rst),
        .req_i        (req),
        .code_ready_i (code_ready),
        .code_valid_o (code_valid),
        .code_o       (code)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    bit           m_valid = 1'b0;
    int           m_code  = 0;
    int           m_ptr   = 0;
    logic [N-1:0] m_pend  = '0;

    // The first eligible line found by walking upward from p, modulo N.
    function automatic int pick(input logic [N-1:0] e, input int p);
        int  r;
        bit  found;
        r     = p;
        found = 1'b0;
        for (int k = 0; k < N; k++) begin
            if (!found && e[(p + k) % N]) begin
                r     = (p + k) % N;
                found = 1'b1;
            end
        end
        return r;
    endfunction

    function automatic logic [N-1:0] model_elig(input logic [N-1:0] r, input logic [N-1:0] p);
`ifdef RR_ENCODER_LATCH_EN
        return r | p;
`else
        return r;
`endif
    endfunction

    function automatic logic [N-1:0] next_pend(input logic [N-1:0] p, input logic [N-1:0] r,
                                               input bit hs, input int c);
        logic [N-1:0] n;
        n = p | r;
        if (hs) n[c] = r[c];
        return n;
    endfunction

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_valid <= 1'b0;
            m_code  <= 0;
            m_ptr   <= 0;
            m_pend  <= '0;
        end else begin
            if (!m_valid) begin
                if (model_elig(req, m_pend) != '0) begin
                    m_code  <= pick(model_elig(req, m_pend), m_ptr);
                    m_valid <= 1'b1;
                end
            end else if (code_ready) begin
                m_valid <= 1'b0;
                m_ptr   <= (m_code + 1) % N;
            end
            m_pend <= next_pend(m_pend, req, m_valid && code_ready, m_code);
        end
    end

    // Compare the DUT against the model away from the active edge.
    always @(negedge clk) begin
        if (!rst) begin
            check("model_valid", 32'(code_valid), 32'(m_valid));
            check("model_code",  32'(code),       32'(m_code));
        end
    end

    // ---------------- directed stimulus ----------------
    task automatic step(input logic [N-1:0] r, input logic rdy);
        req        = r;
        code_ready = rdy;
        @(negedge clk);
    endtask

    task automatic expect_offer(input string name, input int c);
        check({name, "_valid"}, 32'(code_valid), 32'd1);
        check({name, "_code"},  32'(code),       32'(c));
    endtask

    task automatic expect_idle(input string name);
        check({name, "_valid"}, 32'(code_valid), 32'd0);
    endtask

    // Assert reset between clock edges. The outputs must clear at once.
    task automatic do_reset(input string name);
        #2 rst = 1'b1;
        #1;
        check({name, "_async_valid"}, 32'(code_valid), 32'd0);
        check({name, "_async_code"},  32'(code),       32'd0);
        @(negedge clk);
        rst = 1'b0;
    endtask

    initial begin
        rst        = 1'b1;
        req        = '0;
        code_ready = 1'b0;
        repeat (2) @(negedge clk);
        check("reset_valid", 32'(code_valid), 32'd0);
        check("reset_code",  32'(code),       32'd0);
        rst = 1'b0;

        // Round-robin: all lines held, ready high. Codes 0,1,2,3,0,1 appear every other cycle.
        for (int k = 0; k < 6; k++) begin
            step(4'b1111, 1'b1);
            expect_offer("rr_offer", k % N);
            step(4'b1111, 1'b1);
            expect_idle("rr_gap");
        end

        // Reset mid-offer. The pointer is 2 here, so 0100 wins code 2.
        step(4'b0100, 1'b0);
        expect_offer("pre_reset", 2);
        do_reset("mid_offer");
        // 0101 yields 0 only if the pointer went back to 0 (from 2 it would yield 2).
        step(4'b0101, 1'b0);
        expect_offer("post_reset", 0);
        do_reset("clear1");

        // Wrap: a grant of 2 sets the pointer to 3, then 0011 gives 0, then 1.
        step(4'b0100, 1'b0);
        expect_offer("wrap_g2", 2);
        step(4'b0000, 1'b1);
        expect_idle("wrap_hs2");
        step(4'b0011, 1'b1);
        expect_offer("wrap_g0", 0);
        step(4'b0011, 1'b1);
        expect_idle("wrap_hs0");
        step(4'b0011, 1'b0);
        expect_offer("wrap_g1", 1);
        do_reset("clear2");

        // Backpressure: the offer of 2 stays stable while req drops and ready is low.
        step(4'b0100, 1'b0);
        expect_offer("bp_start", 2);
        for (int k = 0; k < 5; k++) begin
            step(4'b0000, 1'b0);
            expect_offer("bp_hold", 2);
        end
        step(4'b0000, 1'b1);
        expect_idle("bp_done");

        // Idle: no requests for 10 cycles.
        for (int k = 0; k < 10; k++) begin
            step(4'b0000, 1'b0);
            expect_idle("idle");
        end

        // Pulse of 1000 during an offer of code 1 (the pointer is 3, so 0010 wins 1).
        step(4'b0010, 1'b0);
        expect_offer("latch_g1", 1);
        step(4'b1000, 1'b0);
        expect_offer("latch_hold1", 1);
        step(4'b0000, 1'b1);
        expect_idle("latch_hs1");
`ifdef RR_ENCODER_LATCH_EN
        step(4'b0000, 1'b0);
        expect_offer("latch_g3", 3);
        step(4'b0000, 1'b1);
        expect_idle("latch_hs3");
`else
        for (int k = 0; k < 6; k++) begin
            step(4'b0000, 1'b0);
            expect_idle("pulse_lost");
        end
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
